// File: rtl/fm_row_packer.sv
`default_nettype none
// ============================================================================
// Module   : fm_row_packer
// Purpose  : Packs a stream of feature-map words into 1024-bit rows and writes
//            each completed row to a BRAM port A, one row address per row.
// Revision : 1.0 - initial release
// ============================================================================
module fm_row_packer #(
   parameter int WORD_W        = 32,
   parameter int WORDS_PER_ROW = 32,
   parameter int ROWS          = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            frame_start,
   input  logic                            in_valid,
   input  logic [WORD_W-1:0]               in_data,
   output logic                            in_ready,
   output logic                            fm_bram_ena,
   output logic                            fm_bram_wea,
   output logic [4:0]                      fm_bram_addra,
   output logic [WORD_W*WORDS_PER_ROW-1:0] fm_bram_dina,
   output logic                            busy,
   output logic                            frame_done
);

   localparam int c_ROW_W = WORD_W * WORDS_PER_ROW;
   localparam int c_CNT_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST_WORD = c_CNT_W'(WORDS_PER_ROW - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
   localparam logic [4:0]         c_LAST_ROW  = 5'(ROWS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               r_state;
   logic [4:0]           r_row;
   logic [c_CNT_W-1:0]   r_word_cnt;
   logic [c_ROW_W-1:0]   r_row_data;
   logic [c_ROW_W-1:0]   w_row_merged;
   logic                 w_accept;

   // in_ready is registered high exactly while in FILL, so it doubles as the state qualifier
   assign w_accept = in_valid & in_ready;

   always_comb begin
      w_row_merged = r_row_data;
      w_row_merged[int'(r_word_cnt) * WORD_W +: WORD_W] = in_data;
   end

   // Outputs are registered alongside the state: each transition sets the outputs of the state it enters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_row         <= '0;
         r_word_cnt    <= '0;
         r_row_data    <= '0;
         in_ready      <= 1'b0;
         fm_bram_ena   <= 1'b0;
         fm_bram_wea   <= 1'b0;
         fm_bram_addra <= '0;
         fm_bram_dina  <= '0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (frame_start) begin
                  r_state    <= S_FILL;
                  r_row      <= '0;
                  r_word_cnt <= '0;
                  in_ready   <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            S_FILL: begin
               if (w_accept) begin
                  r_row_data <= w_row_merged;
                  if (r_word_cnt == c_LAST_WORD) begin
                     r_word_cnt    <= '0;
                     r_state       <= S_WRITE;
                     in_ready      <= 1'b0;
                     fm_bram_ena   <= 1'b1;
                     fm_bram_wea   <= 1'b1;
                     fm_bram_addra <= r_row;
                     fm_bram_dina  <= w_row_merged;
                  end else begin
                     r_word_cnt <= r_word_cnt + c_CNT_ONE;
                  end
               end
            end
            S_WRITE: begin
               fm_bram_ena <= 1'b0;
               fm_bram_wea <= 1'b0;
               if (r_row == c_LAST_ROW) begin
                  r_state    <= S_DONE;
                  frame_done <= 1'b1;
               end else begin
                  r_row    <= r_row + 5'd1;
                  r_state  <= S_FILL;
                  in_ready <= 1'b1;
               end
            end
            S_DONE: begin
               frame_done <= 1'b0;
               busy       <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/fm_row_packer.md
FM_ROW_PACKER -- requirements
Module: fm_row_packer

Interface
REQ-001 Parameters: WORD_W, 32, width of one input feature-map word in bits.
REQ-002 Parameters: WORDS_PER_ROW, 32, input words packed into one BRAM row; WORD_W*WORDS_PER_ROW SHALL equal 1024.
REQ-003 Parameters: ROWS, 32, rows per feature map; addressed by the 5-bit fm_bram_addra.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 frame_start  input  1  one-cycle pulse that begins packing of a new feature map.
REQ-007 in_valid  input  1  input word valid.
REQ-008 in_data  input  WORD_W  input feature-map word.
REQ-009 in_ready  output  1  packer accepts in_data this cycle.
REQ-010 fm_bram_ena  output  1  BRAM port-A enable.
REQ-011 fm_bram_wea  output  1  BRAM port-A write enable.
REQ-012 fm_bram_addra  output  5  BRAM port-A row address.
REQ-013 fm_bram_dina  output  1024  BRAM port-A write data.
REQ-014 busy  output  1  high from the cycle after an accepted frame_start until frame_done.
REQ-015 frame_done  output  1  one-cycle pulse after the last row write.

Function
REQ-016 The block SHALL implement states IDLE, FILL, WRITE, DONE.
REQ-017 IDLE: in_ready=0, no BRAM access; frame_start=1 -> FILL with row=0, word count=0.
REQ-018 frame_start SHALL be ignored in every state other than IDLE.
REQ-019 FILL: in_ready=1; a word is accepted when in_valid=1 and in_ready=1.
REQ-020 Accepted word k (0-based within a row) SHALL be placed at bits [k*WORD_W+WORD_W-1 : k*WORD_W] of the row register (first word in LSBs).
REQ-021 On acceptance of word WORDS_PER_ROW-1 the next state SHALL be WRITE and the word count SHALL wrap to 0.
REQ-022 WRITE (exactly one cycle): fm_bram_ena=1, fm_bram_wea=1, fm_bram_addra=row, fm_bram_dina=complete row register; in_ready=0.
REQ-023 From WRITE: if row=ROWS-1 -> DONE, else row increments by 1 and -> FILL.
REQ-024 DONE (exactly one cycle): frame_done=1, busy=1, in_ready=0, no BRAM access; -> IDLE.
REQ-025 fm_bram_ena and fm_bram_wea SHALL be 0 in every state except WRITE.
REQ-026 in_valid gaps in FILL SHALL stall packing without losing or reordering words.
REQ-027 Latency: BRAM write of a row SHALL occur in the cycle immediately after its last word is accepted; frame_done SHALL occur the cycle after the write of row ROWS-1.
REQ-028 Peak throughput: one row per WORDS_PER_ROW+1 cycles.
REQ-029 fm_bram_dina and fm_bram_addra SHALL be registered outputs; values outside WRITE are don't-care but SHALL not toggle ena/wea.
REQ-030 busy SHALL be 1 in FILL, WRITE, DONE and 0 in IDLE.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, row=0, word count=0, row register=0.
REQ-032 During and after reset: in_ready=0, fm_bram_ena=0, fm_bram_wea=0, fm_bram_addra=0, fm_bram_dina=0, busy=0, frame_done=0.
REQ-033 Reset mid-frame SHALL discard the partial row with no BRAM write and no frame_done; a new frame_start is required.

Verification
REQ-034 frame_start, then 1024 words in_data=n (n=0..1023) with in_valid held 1 -> 32 writes, row r at addr r with word k = 32r+k in bits [32k+31:32k], one write every 33 cycles, frame_done pulses once, busy falls with it.
REQ-035 in_valid toggled 1/0 every cycle for one row -> identical row contents to REQ-034, write delayed accordingly, in_ready=0 only in WRITE/IDLE/DONE.
REQ-036 frame_start pulsed again while in FILL at word 10 -> ignored; row 0 still completes with the original 32 words.
REQ-037 rst asserted after 20 words of row 5 -> no write to addr 5, all outputs 0 next cycle; new frame restarts at addr 0.
REQ-038 in_valid=1 with no frame_start -> in_ready=0, no BRAM access, busy=0 indefinitely.
REQ-039 Last word of row 31 accepted -> WRITE addr 31 next cycle, frame_done the cycle after, in_ready=0 from then until next frame_start.
